// File: rtl/lcd_drive_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_drive_pkg
//  Description : Shared definitions for the lcd_drive_ctrl AHB slave:
//                field widths, register word indices, CTRL/STATUS bit
//                positions, FSM state encoding, the shadow/active
//                configuration record, and a field read-back helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_drive_pkg;

    // Field widths
    localparam int W_SIZE       = 12;
    localparam int W_DELAY      = 12;
    localparam int W_FRAME_SIZE = 2 * W_SIZE + 1;
    localparam int IMG_PIX_W    = 8;
    localparam int W_FCNT       = 16;

    // Register word indices (HADDR[5:2])
    localparam logic [3:0] C_IDX_WIDTH       = 4'd0;
    localparam logic [3:0] C_IDX_HEIGHT      = 4'd1;
    localparam logic [3:0] C_IDX_START_UP    = 4'd2;
    localparam logic [3:0] C_IDX_VSYNC_CYC   = 4'd3;
    localparam logic [3:0] C_IDX_VSYNC_DLY   = 4'd4;
    localparam logic [3:0] C_IDX_HSYNC_DLY   = 4'd5;
    localparam logic [3:0] C_IDX_FTRANS_DLY  = 4'd6;
    localparam logic [3:0] C_IDX_DATA_COUNT  = 4'd7;
    localparam logic [3:0] C_IDX_BR_MODE     = 4'd8;
    localparam logic [3:0] C_IDX_BR_VALUE    = 4'd9;
    localparam logic [3:0] C_IDX_CTRL        = 4'd10;
    localparam logic [3:0] C_IDX_STATUS      = 4'd11;

    // CTRL bit positions
    localparam int C_CTRL_START  = 0;
    localparam int C_CTRL_CONT   = 1;
    localparam int C_CTRL_STOP   = 2;
    localparam int C_CTRL_IRQ_EN = 3;

    // STATUS bit positions
    localparam int C_STAT_BUSY     = 0;
    localparam int C_STAT_DONE     = 1;
    localparam int C_STAT_FCNT_LSB = 16;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_KICK = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Programmable frame configuration (used for both shadow and active copies)
    typedef struct packed {
        logic [W_SIZE-1:0]       width;
        logic [W_SIZE-1:0]       height;
        logic [W_DELAY-1:0]      start_up_delay;
        logic [W_DELAY-1:0]      vsync_cycle;
        logic [W_DELAY-1:0]      vsync_delay;
        logic [W_DELAY-1:0]      hsync_delay;
        logic [W_DELAY-1:0]      frame_trans_delay;
        logic [W_FRAME_SIZE-1:0] data_count;
        logic                    br_mode;
        logic [IMG_PIX_W-1:0]    br_value;
    } cfg_t;

    // Zero-extended read-back of a configuration field; non-config indices read 0.
    function automatic logic [31:0] cfg_rd(input cfg_t c, input logic [3:0] idx);
        logic [31:0] r;
        r = '0;
        case (idx)
            C_IDX_WIDTH:      r[W_SIZE-1:0]       = c.width;
            C_IDX_HEIGHT:     r[W_SIZE-1:0]       = c.height;
            C_IDX_START_UP:   r[W_DELAY-1:0]      = c.start_up_delay;
            C_IDX_VSYNC_CYC:  r[W_DELAY-1:0]      = c.vsync_cycle;
            C_IDX_VSYNC_DLY:  r[W_DELAY-1:0]      = c.vsync_delay;
            C_IDX_HSYNC_DLY:  r[W_DELAY-1:0]      = c.hsync_delay;
            C_IDX_FTRANS_DLY: r[W_DELAY-1:0]      = c.frame_trans_delay;
            C_IDX_DATA_COUNT: r[W_FRAME_SIZE-1:0] = c.data_count;
            C_IDX_BR_MODE:    r[0]                = c.br_mode;
            C_IDX_BR_VALUE:   r[IMG_PIX_W-1:0]    = c.br_value;
            default:          r                   = '0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_drive_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_drive_regbank
//  Description : AHB-Lite decode and register storage for lcd_drive_ctrl.
//                Holds the shadow configuration, CTRL (CONT, IRQ_EN) and
//                STATUS (done_sticky, frame count). START/STOP writes are
//                presented as single-cycle request pulses in the write
//                data phase.
//  Revision    : 1.0 - initial release
//  Ports       : clk_i/rst_ni       clock, async active-low reset
//                hsel_i..hwdata_i   AHB-Lite slave inputs
//                hrdata_o           registered read data
//                busy_i             sequencer not idle
//                done_evt_i         sequencer in DONE this cycle
//                cfg_o              shadow configuration
//                start_req_o        CTRL.START written as 1 (pulse)
//                stop_req_o         CTRL.STOP written as 1 (pulse)
//                cont_o, irq_en_o   CTRL mode bits
//                done_sticky_o      STATUS.done_sticky
// ============================================================================
module lcd_drive_regbank
    import lcd_drive_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hsel_i,
    input  logic        hready_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [31:0] hwdata_i,
    output logic [31:0] hrdata_o,
    input  logic        busy_i,
    input  logic        done_evt_i,
    output cfg_t        cfg_o,
    output logic        start_req_o,
    output logic        stop_req_o,
    output logic        cont_o,
    output logic        irq_en_o,
    output logic        done_sticky_o
);

    logic              addr_valid;
    logic              wr_pend_q;
    logic [3:0]        wr_idx_q;
    cfg_t              cfg_q, cfg_d;
    logic              cont_q, cont_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              done_clr;
    logic [W_FCNT-1:0] fcnt_q, fcnt_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic [31:0]       ctrl_rd;
    logic [31:0]       stat_rd;
    logic              w_unused;

    // Only word offsets 0x00..0x3C are decoded; size is ignored (word access).
    assign w_unused   = ^{haddr_i[31:6], haddr_i[1:0], htrans_i[0], hsize_i, hwdata_i[31:25]};
    assign addr_valid = hsel_i & hready_i & htrans_i[1];

    // Write commit in the data phase, plus CTRL/STATUS side effects.
    always_comb begin
        cfg_d       = cfg_q;
        cont_d      = cont_q;
        irq_en_d    = irq_en_q;
        start_req_o = 1'b0;
        stop_req_o  = 1'b0;
        done_clr    = 1'b0;
        if (wr_pend_q) begin
            case (wr_idx_q)
                C_IDX_WIDTH:      cfg_d.width             = hwdata_i[W_SIZE-1:0];
                C_IDX_HEIGHT:     cfg_d.height            = hwdata_i[W_SIZE-1:0];
                C_IDX_START_UP:   cfg_d.start_up_delay    = hwdata_i[W_DELAY-1:0];
                C_IDX_VSYNC_CYC:  cfg_d.vsync_cycle       = hwdata_i[W_DELAY-1:0];
                C_IDX_VSYNC_DLY:  cfg_d.vsync_delay       = hwdata_i[W_DELAY-1:0];
                C_IDX_HSYNC_DLY:  cfg_d.hsync_delay       = hwdata_i[W_DELAY-1:0];
                C_IDX_FTRANS_DLY: cfg_d.frame_trans_delay = hwdata_i[W_DELAY-1:0];
                C_IDX_DATA_COUNT: cfg_d.data_count        = hwdata_i[W_FRAME_SIZE-1:0];
                C_IDX_BR_MODE:    cfg_d.br_mode           = hwdata_i[0];
                C_IDX_BR_VALUE:   cfg_d.br_value          = hwdata_i[IMG_PIX_W-1:0];
                C_IDX_CTRL: begin
                    start_req_o = hwdata_i[C_CTRL_START];
                    stop_req_o  = hwdata_i[C_CTRL_STOP];
                    cont_d      = hwdata_i[C_CTRL_CONT];
                    irq_en_d    = hwdata_i[C_CTRL_IRQ_EN];
                end
                C_IDX_STATUS:     done_clr                = hwdata_i[C_STAT_DONE];
                default: ;
            endcase
        end
        // A frame completing in the same cycle as the W1C keeps the flag set.
        done_d = done_evt_i ? 1'b1 : (done_clr ? 1'b0 : done_q);
        fcnt_d = done_evt_i ? fcnt_q + 1'b1 : fcnt_q;
    end

    // Read data is taken from the next-state values so that a read whose
    // address phase overlaps a write data phase returns the new contents.
    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[C_CTRL_CONT]    = cont_d;
        ctrl_rd[C_CTRL_IRQ_EN]  = irq_en_d;
        stat_rd                 = '0;
        stat_rd[C_STAT_BUSY]    = busy_i;
        stat_rd[C_STAT_DONE]    = done_d;
        stat_rd[C_STAT_FCNT_LSB +: W_FCNT] = fcnt_d;
        hrdata_d = '0;
        if (addr_valid && !hwrite_i) begin
            case (haddr_i[5:2])
                C_IDX_CTRL:   hrdata_d = ctrl_rd;
                C_IDX_STATUS: hrdata_d = stat_rd;
                default:      hrdata_d = cfg_rd(cfg_d, haddr_i[5:2]);
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            cfg_q     <= '0;
            cont_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            fcnt_q    <= '0;
            hrdata_q  <= '0;
        end else begin
            wr_pend_q <= addr_valid & hwrite_i;
            wr_idx_q  <= haddr_i[5:2];
            cfg_q     <= cfg_d;
            cont_q    <= cont_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            fcnt_q    <= fcnt_d;
            hrdata_q  <= hrdata_d;
        end
    end

    assign hrdata_o      = hrdata_q;
    assign cfg_o         = cfg_q;
    assign cont_o        = cont_q;
    assign irq_en_o      = irq_en_q;
    assign done_sticky_o = done_q;

endmodule
`default_nettype wire

// File: rtl/lcd_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_drive_ctrl
//  Description : AHB-Lite configuration/sequencing slave for the lcd_drive
//                engine. Shadow configuration is copied to the active
//                outputs only at frame boundaries (LOAD). Issues one start
//                pulse per frame, supports single-shot and continuous modes,
//                and raises a level end-of-frame interrupt.
//  Revision    : 1.0 - initial release
//  Ports       : HCLK/HRESETn            clock, async active-low reset
//                HSEL..HWDATA            AHB-Lite slave inputs
//                HRDATA/HREADYOUT/HRESP  AHB-Lite slave outputs (zero wait, OKAY)
//                o_width..o_br_value     active frame configuration
//                o_start                 one-cycle frame start to lcd_drive
//                i_frame_done            one-cycle end-of-frame from lcd_drive
//                o_irq                   done_sticky & irq_en
// ============================================================================
module lcd_drive_ctrl
    import lcd_drive_pkg::*;
(
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic                    HREADY,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    output logic [W_SIZE-1:0]       o_width,
    output logic [W_SIZE-1:0]       o_height,
    output logic [W_DELAY-1:0]      o_start_up_delay,
    output logic [W_DELAY-1:0]      o_vsync_cycle,
    output logic [W_DELAY-1:0]      o_vsync_delay,
    output logic [W_DELAY-1:0]      o_hsync_delay,
    output logic [W_DELAY-1:0]      o_frame_trans_delay,
    output logic [W_FRAME_SIZE-1:0] o_data_count,
    output logic                    o_br_mode,
    output logic [IMG_PIX_W-1:0]    o_br_value,
    output logic                    o_start,
    input  logic                    i_frame_done,
    output logic                    o_irq
);

    state_e state_q, state_d;
    logic   stop_pend_q, stop_pend_d;
    cfg_t   act_q;
    cfg_t   shadow;
    logic   start_req;
    logic   stop_req;
    logic   cont;
    logic   irq_en;
    logic   done_sticky;
    logic   busy;
    logic   done_evt;

    assign busy     = (state_q != ST_IDLE);
    assign done_evt = (state_q == ST_DONE);

    lcd_drive_regbank u_regbank (
        .clk_i         (HCLK),
        .rst_ni        (HRESETn),
        .hsel_i        (HSEL),
        .hready_i      (HREADY),
        .haddr_i       (HADDR),
        .htrans_i      (HTRANS),
        .hwrite_i      (HWRITE),
        .hsize_i       (HSIZE),
        .hwdata_i      (HWDATA),
        .hrdata_o      (HRDATA),
        .busy_i        (busy),
        .done_evt_i    (done_evt),
        .cfg_o         (shadow),
        .start_req_o   (start_req),
        .stop_req_o    (stop_req),
        .cont_o        (cont),
        .irq_en_o      (irq_en),
        .done_sticky_o (done_sticky)
    );

    // Frame sequencer: next state and stop bookkeeping.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        // A STOP while a frame is in flight only takes effect at its end.
        if (stop_req && busy) begin
            stop_pend_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                // START and STOP in one write: STOP wins, no frame.
                if (start_req && !stop_req) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_KICK;
            ST_KICK: state_d = ST_RUN;
            ST_RUN: begin
                if (i_frame_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                stop_pend_d = 1'b0;
                if (cont && !stop_pend_q && !stop_req) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            act_q       <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            // The only point where the active configuration may change.
            if (state_q == ST_LOAD) begin
                act_q <= shadow;
            end
        end
    end

    assign o_start             = (state_q == ST_KICK);
    assign o_irq               = done_sticky & irq_en;
    assign HREADYOUT           = 1'b1;
    assign HRESP               = 2'b00;

    assign o_width             = act_q.width;
    assign o_height            = act_q.height;
    assign o_start_up_delay    = act_q.start_up_delay;
    assign o_vsync_cycle       = act_q.vsync_cycle;
    assign o_vsync_delay       = act_q.vsync_delay;
    assign o_hsync_delay       = act_q.hsync_delay;
    assign o_frame_trans_delay = act_q.frame_trans_delay;
    assign o_data_count        = act_q.data_count;
    assign o_br_mode           = act_q.br_mode;
    assign o_br_value          = act_q.br_value;

endmodule
`default_nettype wire

// File: tb/tb_lcd_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_drive_ctrl
//  Description : Self-checking bench for lcd_drive_ctrl: register table,
//                frame sequencing sequences and randomized config/frame runs
//                against a shadow/snapshot reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_drive_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [11:0] o_width, o_height, o_start_up_delay, o_vsync_cycle;
    logic [11:0] o_vsync_delay, o_hsync_delay, o_frame_trans_delay;
    logic [24:0] o_data_count;
    logic        o_br_mode;
    logic [7:0]  o_br_value;
    logic        o_start;
    logic        i_frame_done = 1'b0;
    logic        o_irq;

    lcd_drive_ctrl dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .o_width(o_width), .o_height(o_height), .o_start_up_delay(o_start_up_delay),
        .o_vsync_cycle(o_vsync_cycle), .o_vsync_delay(o_vsync_delay),
        .o_hsync_delay(o_hsync_delay), .o_frame_trans_delay(o_frame_trans_delay),
        .o_data_count(o_data_count), .o_br_mode(o_br_mode), .o_br_value(o_br_value),
        .o_start(o_start), .i_frame_done(i_frame_done), .o_irq(o_irq)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_start = 0;

    // Count o_start pulses seen by the engine side.
    always @(posedge HCLK) if (HRESETn && o_start) n_start <= n_start + 1;

    // Reference model: shadow register contents and the snapshot the
    // engine should currently see.
    logic [31:0] shadow_m [10];
    logic [31:0] snap_m   [10];

    function automatic logic [31:0] mask_of(input int idx);
        int w;
        if (idx < 7)       w = 12;
        else if (idx == 7) w = 25;
        else if (idx == 8) w = 1;
        else if (idx == 9) w = 8;
        else               w = 0;
        return (32'h1 << w) - 32'h1;
    endfunction

    function automatic logic [31:0] act_val(input int idx);
        case (idx)
            0: return {20'h0, o_width};
            1: return {20'h0, o_height};
            2: return {20'h0, o_start_up_delay};
            3: return {20'h0, o_vsync_cycle};
            4: return {20'h0, o_vsync_delay};
            5: return {20'h0, o_hsync_delay};
            6: return {20'h0, o_frame_trans_delay};
            7: return {7'h0, o_data_count};
            8: return {31'h0, o_br_mode};
            default: return {24'h0, o_br_value};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_active(input string tag);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_active%0d", tag, i), act_val(i), snap_m[i]);
        end
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
        @(posedge HCLK); #1;
        bus_idle(); HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
        @(posedge HCLK); #1;
        bus_idle();
        d = HRDATA;
    endtask

    // Back-to-back write then read of the same register (read address phase
    // overlaps the write data phase).
    task automatic wr_then_rd(input logic [7:0] a, input logic [31:0] d, output logic [31:0] r);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
        @(posedge HCLK); #1;
        HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
        bus_idle();
        r = HRDATA;
    endtask

    task automatic pulse_done();
        i_frame_done = 1'b1;
        @(posedge HCLK); #1;
        i_frame_done = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge HCLK); #1;
            if (o_start) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: o_start got none within %0d cycles, required pulse", tag, budget);
        end
    endtask

    task automatic do_reset();
        bus_idle();
        i_frame_done = 1'b0;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        for (int i = 0; i < 10; i++) begin
            shadow_m[i] = '0;
            snap_m[i]   = '0;
        end
    endtask

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] rd;
    int          s0;
    int          exp_count;

    initial begin
        vecs[0]  = '{8'h00, 32'hFFFF_FFFF, 32'h0000_0FFF};
        vecs[1]  = '{8'h04, 32'h0000_0ABC, 32'h0000_0ABC};
        vecs[2]  = '{8'h08, 32'hFFFF_F123, 32'h0000_0123};
        vecs[3]  = '{8'h0C, 32'h0000_0FFF, 32'h0000_0FFF};
        vecs[4]  = '{8'h10, 32'h1234_5678, 32'h0000_0678};
        vecs[5]  = '{8'h14, 32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{8'h18, 32'hA5A5_A5A5, 32'h0000_05A5};
        vecs[7]  = '{8'h1C, 32'hFFFF_FFFF, 32'h01FF_FFFF};
        vecs[8]  = '{8'h20, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[9]  = '{8'h20, 32'h0000_0003, 32'h0000_0001};
        vecs[10] = '{8'h24, 32'h0001_2345, 32'h0000_0045};
        vecs[11] = '{8'h28, 32'h0000_000F, 32'h0000_000A};   // START+STOP: no frame
        vecs[12] = '{8'h2C, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[13] = '{8'h28, 32'h0000_0000, 32'h0000_0000};
        vecs[14] = '{8'h30, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[15] = '{8'h3C, 32'hFFFF_FFFF, 32'h0000_0000};

        // ---------------- reset state ----------------
        do_reset();
        check("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("reset_hresp", {30'h0, HRESP}, 32'h0);
        check("reset_ostart", {31'h0, o_start}, 32'h0);
        check("reset_irq", {31'h0, o_irq}, 32'h0);
        check_active("reset");
        for (int i = 0; i < 16; i++) begin
            ahb_read(8'(i * 4), rd);
            check($sformatf("reset_rd_%02h", i * 4), rd, 32'h0);
        end

        // ---------------- register table ----------------
        s0 = n_start;
        for (int i = 0; i < 16; i++) begin
            wr_then_rd(vecs[i].addr, vecs[i].wdata, rd);
            check($sformatf("table_%0d_off%02h", i, vecs[i].addr), rd, vecs[i].exp);
        end
        repeat (5) @(posedge HCLK); #1;
        check("table_no_start", n_start - s0, 0);

        // ---------------- single-shot frame ----------------
        do_reset();
        ahb_write(8'h00, 768);
        ahb_write(8'h04, 512);
        ahb_write(8'h1C, 196608);
        ahb_write(8'h24, 32'h50);
        ahb_write(8'h28, 32'h1);
        check("single_start_lat1", {31'h0, o_start}, 32'h0);
        @(posedge HCLK); #1;
        check("single_start_lat2", {31'h0, o_start}, 32'h1);
        check("single_width", {20'h0, o_width}, 768);
        check("single_height", {20'h0, o_height}, 512);
        check("single_dcount", {7'h0, o_data_count}, 196608);
        check("single_brval", {24'h0, o_br_value}, 32'h50);
        @(posedge HCLK); #1;
        check("single_start_width", {31'h0, o_start}, 32'h0);
        ahb_read(8'h2C, rd);
        check("single_busy", rd, 32'h0000_0001);
        repeat (10) @(posedge HCLK); #1;
        pulse_done();
        repeat (2) @(posedge HCLK); #1;
        ahb_read(8'h2C, rd);
        check("single_status_done", rd, 32'h0001_0002);
        check("single_irq_disabled", {31'h0, o_irq}, 32'h0);

        // ---------------- continuous mode ----------------
        do_reset();
        s0 = n_start;
        ahb_write(8'h00, 768);
        ahb_write(8'h04, 512);
        ahb_write(8'h28, 32'h3);
        wait_start("cont_f1", 10);
        check("cont_f1_height", {20'h0, o_height}, 512);
        repeat (10) @(posedge HCLK); #1;
        ahb_write(8'h04, 256);
        repeat (5) @(posedge HCLK); #1;
        check("cont_f1_height_hold", {20'h0, o_height}, 512);
        repeat (80) @(posedge HCLK); #1;
        pulse_done();
        wait_start("cont_f2", 10);
        check("cont_f2_height", {20'h0, o_height}, 256);
        repeat (100) @(posedge HCLK); #1;
        pulse_done();
        wait_start("cont_f3", 10);
        repeat (20) @(posedge HCLK); #1;
        ahb_write(8'h28, 32'h6);
        repeat (70) @(posedge HCLK); #1;
        pulse_done();
        repeat (150) @(posedge HCLK); #1;
        check("cont_pulses", n_start - s0, 3);
        ahb_read(8'h2C, rd);
        check("cont_status", rd, 32'h0003_0002);

        // ---------------- irq and W1C ----------------
        do_reset();
        ahb_write(8'h28, 32'h9);
        wait_start("irq_f1", 10);
        repeat (5) @(posedge HCLK); #1;
        pulse_done();
        repeat (2) @(posedge HCLK); #1;
        check("irq_set", {31'h0, o_irq}, 32'h1);
        ahb_write(8'h2C, 32'h2);
        check("irq_w1c", {31'h0, o_irq}, 32'h0);
        ahb_write(8'h28, 32'h9);
        wait_start("irq_f2", 10);
        repeat (3) @(posedge HCLK); #1;
        // frame_done and W1C address phase together: W1C data phase lands on DONE
        i_frame_done = 1'b1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h2C;
        @(posedge HCLK); #1;
        i_frame_done = 1'b0;
        bus_idle(); HWDATA = 32'h2;
        @(posedge HCLK); #1;
        check("irq_w1c_vs_done", {31'h0, o_irq}, 32'h1);
        ahb_read(8'h2C, rd);
        check("irq_w1c_vs_done_status", rd, 32'h0002_0002);

        // ---------------- ignored START / frame_done ----------------
        s0 = n_start;
        ahb_write(8'h28, 32'h1);
        wait_start("busy_f", 10);
        repeat (3) @(posedge HCLK); #1;
        ahb_write(8'h28, 32'h1);
        repeat (10) @(posedge HCLK); #1;
        pulse_done();
        repeat (3) @(posedge HCLK); #1;
        pulse_done();
        repeat (20) @(posedge HCLK); #1;
        check("ignored_pulses", n_start - s0, 1);
        ahb_read(8'h2C, rd);
        check("ignored_count", rd[31:16], 32'd3);

        // ---------------- async reset mid-frame ----------------
        ahb_write(8'h00, 768);
        ahb_write(8'h28, 32'h1);
        wait_start("rst_f", 10);
        repeat (5) @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        check("rst_width", {20'h0, o_width}, 0);
        check("rst_ostart", {31'h0, o_start}, 0);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(8'h2C, rd);
        check("rst_status", rd, 0);
        ahb_write(8'h00, 100);
        ahb_write(8'h28, 32'h1);
        wait_start("rst_fresh", 10);
        check("rst_fresh_width", {20'h0, o_width}, 100);
        repeat (5) @(posedge HCLK); #1;
        pulse_done();

        // ---------------- randomized frames vs model ----------------
        do_reset();
        exp_count = 0;
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < 6; k++) begin
                int idx;
                logic [31:0] d;
                idx = $urandom_range(0, 15);
                if (idx == 10 || idx == 11) idx = 12;
                d = $urandom;
                ahb_write(8'(idx * 4), d);
                if (idx < 10) shadow_m[idx] = d & mask_of(idx);
            end
            begin
                int idx;
                idx = $urandom_range(0, 13);
                if (idx == 10 || idx == 11) idx = 14;
                ahb_read(8'(idx * 4), rd);
                check($sformatf("rand%0d_rd%02h", it, idx * 4), rd,
                      (idx < 10) ? shadow_m[idx] : 32'h0);
            end
            for (int i = 0; i < 10; i++) snap_m[i] = shadow_m[i];
            ahb_write(8'h28, 32'h1);
            wait_start($sformatf("rand%0d_start", it), 10);
            check_active($sformatf("rand%0d_kick", it));
            begin
                int idx;
                logic [31:0] d;
                idx = $urandom_range(0, 9);
                d = $urandom;
                ahb_write(8'(idx * 4), d);
                shadow_m[idx] = d & mask_of(idx);
            end
            repeat ($urandom_range(1, 20)) @(posedge HCLK);
            #1;
            check_active($sformatf("rand%0d_run", it));
            pulse_done();
            repeat (3) @(posedge HCLK); #1;
            exp_count++;
            ahb_read(8'h2C, rd);
            check($sformatf("rand%0d_status", it), rd, (32'(exp_count) << 16) | 32'h2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
